// File: rtl/mouse_receiver_if.sv
// mouse_receiver_if: PS/2 line inputs, read gating and received-byte result bundle.
// The ERR_COUNT field exists only when MOUSE_RX_ERR_COUNT_EN is defined.
interface mouse_receiver_if;
    logic       CLK_MOUSE_IN;
    logic       DATA_MOUSE_IN;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;
`ifdef MOUSE_RX_ERR_COUNT_EN
    logic [7:0] ERR_COUNT;

    // receiver side: consumes the PS/2 lines, produces the byte result
    modport master (
        input  CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
        output BYTE_READ, BYTE_ERROR_CODE, BYTE_READY, ERR_COUNT
    );
    // consumer side: the mouse master state machine / line driver
    modport slave (
        output CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
        input  BYTE_READ, BYTE_ERROR_CODE, BYTE_READY, ERR_COUNT
    );
`else
    // receiver side: consumes the PS/2 lines, produces the byte result
    modport master (
        input  CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
        output BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
    );
    // consumer side: the mouse master state machine / line driver
    modport slave (
        output CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
        input  BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
    );
`endif
endinterface

// File: rtl/mouse_receiver.sv
// mouse_receiver: PS/2 device-to-host frame deserialiser (start, 8 data LSB-first,
// odd parity, stop) with clock glitch filter and inter-edge timeout.
// Optional error counter output enabled by defining MOUSE_RX_ERR_COUNT_EN.
module mouse_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    mouse_receiver_if.master bus
);
    localparam int unsigned FLT_W = $clog2(FILTER_LEN);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FLT_W-1:0]   flt_cnt;
    logic               flt_level;
    logic               fe;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift_reg;
    logic               par_bit;
    logic               stop_bit;
    logic [7:0]         byte_read;
    logic [1:0]         byte_err;
    logic               byte_ready;
    logic               in_frame_c;
    logic               timeout_c;
    logic               start_c, shift_c, par_c, stop_c, done_c, abort_c;
    logic [1:0]         err_c;

    // Two-flop synchronisers; reset to the idle-high line level so no false edge follows reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= bus.CLK_MOUSE_IN;
            clk_s2 <= clk_s1;
            dat_s1 <= bus.DATA_MOUSE_IN;
            dat_s2 <= dat_s1;
        end
    end

    // Clock glitch filter: level flips after FILTER_LEN consecutive differing samples; fe marks a 1->0 flip
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            flt_cnt   <= '0;
            flt_level <= 1'b1;
            fe        <= 1'b0;
        end else begin
            fe <= 1'b0;
            if (clk_s2 == flt_level) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                flt_cnt   <= '0;
                flt_level <= clk_s2;
                fe        <= flt_level;
            end else begin
                flt_cnt <= flt_cnt + FLT_W'(1);
            end
        end
    end

    // Inter-edge timeout counter: runs inside a frame, cleared on each falling edge, saturating
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            tmo_cnt <= '0;
        end else if (!in_frame_c || fe) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_W'(TIMEOUT_CYCLES)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign in_frame_c = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);
    assign timeout_c  = in_frame_c && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; a timeout takes priority over a coincident edge
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (fe && bus.READ_ENABLE && !dat_s2) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (timeout_c) begin
                    state_next = S_IDLE;
                end else if (fe && (bit_idx == 3'd7)) begin
                    state_next = S_PARITY;
                end
            end
            S_PARITY: begin
                if (timeout_c) begin
                    state_next = S_IDLE;
                end else if (fe) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (timeout_c) begin
                    state_next = S_IDLE;
                end else if (fe) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FSM output decode: datapath strobes for the current state
    always_comb begin
        start_c = 1'b0;
        shift_c = 1'b0;
        par_c   = 1'b0;
        stop_c  = 1'b0;
        done_c  = 1'b0;
        abort_c = timeout_c;
        case (state)
            S_IDLE:   start_c = fe && bus.READ_ENABLE && !dat_s2;
            S_DATA:   shift_c = fe && !timeout_c;
            S_PARITY: par_c   = fe && !timeout_c;
            S_STOP:   stop_c  = fe && !timeout_c;
            S_DONE:   done_c  = 1'b1;
            default:  ;
        endcase
    end

    // Error code of the assembled frame: bit0 even ones over data+parity, bit1 stop low
    assign err_c = {~stop_bit, ~(^shift_reg ^ par_bit)};

    // Frame assembly and registered byte outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            bit_idx    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            stop_bit   <= 1'b0;
            byte_read  <= '0;
            byte_err   <= '0;
            byte_ready <= 1'b0;
        end else begin
            byte_ready <= done_c;
            if (start_c) begin
                bit_idx <= '0;
            end
            if (shift_c) begin
                shift_reg[bit_idx] <= dat_s2;
                bit_idx            <= bit_idx + 3'd1;
            end
            if (par_c) begin
                par_bit <= dat_s2;
            end
            if (stop_c) begin
                stop_bit <= dat_s2;
            end
            if (done_c) begin
                byte_read <= shift_reg;
                byte_err  <= err_c;
            end
        end
    end

    assign bus.BYTE_READ       = byte_read;
    assign bus.BYTE_ERROR_CODE = byte_err;
    assign bus.BYTE_READY      = byte_ready;

`ifdef MOUSE_RX_ERR_COUNT_EN
    logic [7:0] err_count;

    // Saturating count of errored frames and timeout aborts
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            err_count <= '0;
        end else if (((done_c && (err_c != 2'b00)) || abort_c) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    assign bus.ERR_COUNT = err_count;
`endif

endmodule
